mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Consumer of the execute-stage result: takes ALU result (address or value), rs2 store data and
//  dest-reg info, performs loads/stores on a ready-handshaked 64-bit data bus, and hands results to
//  writeback. Stalls upstream while a memory access is outstanding. Sits between exe_stage and wb.
// PARAMETERS
//  XLEN  64  datapath width; must equal `REG_BUS width
// PORTS
//  clk          in   1     clock
//  rst          in   1     synchronous, active-high reset
//  ex_valid     in   1     exe result valid this cycle
//  ex_ready     out  1     stage can accept (transfer = ex_valid & ex_ready)
//  ex_result    in   XLEN  ALU rd_data: effective address for mem ops, else writeback value
//  ex_store     in   XLEN  rs2 data for stores
//  ex_memop     in   2     `MEM_NONE / `MEM_LOAD / `MEM_STORE
//  ex_funct3    in   3     size/sign: 000 B,001 H,010 W,011 D,100 BU,101 HU,110 WU
//  ex_rd_addr   in   5     destination register
//  ex_rd_wen    in   1     destination write enable
//  dmem_req     out  1     bus request, held until dmem_ready
//  dmem_we      out  1     1 = store
//  dmem_addr    out  XLEN  8-byte aligned address {addr[63:3],3'b0}
//  dmem_wdata   out  XLEN  store data shifted to byte lane addr[2:0]
//  dmem_wmask   out  8     byte strobes
//  dmem_ready   in   1     access complete (load data valid same cycle)
//  dmem_rdata   in   XLEN  load data, full aligned doubleword
//  wb_valid     out  1     one-cycle pulse: result for writeback
//  wb_data      out  XLEN  writeback value
//  wb_rd_addr   out  5     destination register
//  wb_rd_wen    out  1     register write enable (0 for stores, misaligned, rd=x0)
//  misalign     out  1     one-cycle pulse with wb_valid: access not naturally aligned
// BEHAVIOUR
//  Reset: state IDLE; ex_ready=1; dmem_req=0, dmem_we=0, dmem_wmask=0; wb_valid=0, wb_rd_wen=0,
//   misalign=0; data/addr outputs 0. Reset mid-access drops dmem_req next edge; late dmem_ready ignored.
//  FSM IDLE/ACCESS/RESP. ex_ready = (state==IDLE). Writeback never back-pressures.
//  IDLE, transfer, MEM_NONE: latch result; wb_valid=1 next cycle (latency 1); stay IDLE.
//  IDLE, transfer, mem op misaligned (H: a[0]; W: a[1:0]; D: a[2:0] nonzero): no bus access;
//   wb_valid=1, misalign=1, wb_rd_wen=0 next cycle; stay IDLE.
//  IDLE, transfer, aligned mem op: latch all inputs -> ACCESS; dmem_req=1 from next cycle.
//  ACCESS: dmem_req, we, addr, wdata, wmask stable until dmem_ready sampled 1 (0 wait states legal).
//   On ready: load -> capture dmem_rdata; -> RESP. dmem_req low in RESP.
//  RESP: wb_valid=1 one cycle -> IDLE. Load-to-wb latency = 2 + wait cycles.
//  Store: wmask = size mask (B 0x01,H 0x03,W 0x0F,D 0xFF) << a[2:0]; wdata = store << 8*a[2:0].
//  Load: shift rdata >> 8*a[2:0]; sign-extend B/H/W, zero-extend BU/HU/WU; D unchanged.
//  wb_rd_wen = ex_rd_wen & (rd!=0) & !store & !misalign. funct3 111 or invalid memop: treat as NONE.
//  Inputs while ex_ready=0 are ignored (upstream holds them).
// STRUCTURE
//  defines.v: `REG_BUS, `MEM_NONE/LOAD/STORE, funct3 size codes.
//  Sub-module mem_align (combinational): store lane shift + wmask, load shift + extend, misalign detect.
// TESTING
//  NONE: ex_result=0x1234, rd=5, wen=1 -> next cycle wb_valid, wb_data=0x1234, wb_rd_wen=1, no dmem_req.
//  LB addr 0x1003, rdata=0x00000000_80000000 (byte3=0x80), ready after 2 waits -> wb_data
//   0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x80; ex_ready=0 throughout; dmem_addr=0x1000.
//  SH addr 0x2006 data 0xBEEF, ready 0 waits -> dmem_wmask=0xC0, wdata[63:48]=0xBEEF, we=1, wb_rd_wen=0.
//  LW addr 0x3002 -> misalign=1, wb_rd_wen=0, no dmem_req; next NONE accepted immediately.
//  Back-to-back: LD 0x4000 then NONE -> second accepted only in cycle after RESP; order preserved.
//  rst asserted while ACCESS with dmem_ready low -> next cycle dmem_req=0, ex_ready=1, no wb_valid.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared width, memop/state enums, size codes and the natural-alignment check
package mem_stage_pkg;
  localparam int XLEN = 64;
  typedef enum logic [1:0] {MEM_NONE = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2} memop_e;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
    return sz == SZ_H ? a[0] : sz == SZ_W ? |a[1:0] : sz == SZ_D ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: store byte-lane shift and strobes, load shift with sign/zero extend, misalign detect
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [2:0]      off,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [7:0]      wmask,
  output logic [XLEN-1:0] load_data,
  output logic            misalign
);
  logic [1:0]      sz;
  logic            sx;
  logic [XLEN-1:0] sh;
  logic [7:0]      base;
  assign sz        = funct3[1:0];
  assign sx        = ~funct3[2];
  assign sh        = rdata >> {off, 3'b000};
  assign base      = sz == SZ_B ? 8'h01 : sz == SZ_H ? 8'h03 : sz == SZ_W ? 8'h0f : 8'hff;
  assign wmask     = base << off;
  assign wdata     = store_data << {off, 3'b000};
  assign misalign  = misaligned(sz, off);
  assign load_data = sz == SZ_B ? {{(XLEN-8){sx & sh[7]}}, sh[7:0]}
                   : sz == SZ_H ? {{(XLEN-16){sx & sh[15]}}, sh[15:0]}
                   : sz == SZ_W ? {{(XLEN-32){sx & sh[31]}}, sh[31:0]}
                   : sh;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: exe-to-writeback memory stage driving a ready-handshaked 64-bit data bus
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] ex_store,
  input  logic [1:0]      ex_memop,
  input  logic [2:0]      ex_funct3,
  input  logic [4:0]      ex_rd_addr,
  input  logic            ex_rd_wen,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wmask,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd_addr,
  output logic            wb_rd_wen,
  output logic            misalign
);
  state_e          state;
  memop_e          op;
  logic            idle;
  logic [2:0]      f3_q;
  logic [2:0]      off_q;
  logic            load_q;
  logic [4:0]      rd_q;
  logic            rd_wen_q;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_load;
  logic [7:0]      al_wmask;
  logic            al_mis;
  assign idle     = state == IDLE;
  assign ex_ready = idle;
  assign op       = (ex_funct3 == 3'b111 || ex_memop == 2'b11) ? MEM_NONE : memop_e'(ex_memop);
  mem_align u_align (
    .funct3     (idle ? ex_funct3 : f3_q),
    .off        (idle ? ex_result[2:0] : off_q),
    .store_data (ex_store),
    .rdata      (dmem_rdata),
    .wdata      (al_wdata),
    .wmask      (al_wmask),
    .load_data  (al_load),
    .misalign   (al_mis)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wmask <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd_addr <= '0;
      wb_rd_wen  <= 1'b0;
      misalign   <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      load_q     <= 1'b0;
      rd_q       <= '0;
      rd_wen_q   <= 1'b0;
    end else begin
      wb_valid  <= 1'b0;
      wb_rd_wen <= 1'b0;
      misalign  <= 1'b0;
      case (state)
        IDLE: if (ex_valid) begin
          if (op == MEM_NONE || al_mis) begin
            wb_valid   <= 1'b1;
            misalign   <= op != MEM_NONE;
            wb_data    <= ex_result;
            wb_rd_addr <= ex_rd_addr;
            wb_rd_wen  <= op == MEM_NONE && ex_rd_wen && |ex_rd_addr;
          end else begin
            state      <= ACCESS;
            dmem_req   <= 1'b1;
            dmem_we    <= op == MEM_STORE;
            dmem_addr  <= {ex_result[XLEN-1:3], 3'b000};
            dmem_wdata <= op == MEM_STORE ? al_wdata : '0;
            dmem_wmask <= op == MEM_STORE ? al_wmask : '0;
            f3_q       <= ex_funct3;
            off_q      <= ex_result[2:0];
            load_q     <= op == MEM_LOAD;
            rd_q       <= ex_rd_addr;
            rd_wen_q   <= op == MEM_LOAD && ex_rd_wen && |ex_rd_addr;
          end
        end
        ACCESS: if (dmem_ready) begin
          state      <= RESP;
          dmem_req   <= 1'b0;
          dmem_we    <= 1'b0;
          dmem_wmask <= '0;
          wb_valid   <= 1'b1;
          wb_data    <= load_q ? al_load : '0;
          wb_rd_addr <= rd_q;
          wb_rd_wen  <= rd_wen_q;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
